rf_wb_queue: RTL and testbench
==============================

// Module: rf_wb_queue
// PURPOSE
//  Write-back buffer that sits directly upstream of the 8x16 register file and drives its write port.
//  Execute/memory results enter through a valid/ready handshake and are buffered in a small circular FIFO.
//  One entry retires to the RF per cycle unless wr_hold is high.
//  Also provides bypass and hazard lookup of pending (not yet committed) writes for both RF read selects.
// PARAMETERS
//  DEPTH   2   queue entries; power of 2, legal range 2..8
//  DATA_W  16  write data width; must equal the RF data width
//  REG_AW  3   register select width (8 registers)
// PORTS
//  clk             in   1            system clock; all state updates on posedge
//  rst             in   1            reset, asynchronous, active-low
//  in_valid        in   1            producer offers an entry
//  in_ready        out  1            queue can accept; an entry transfers when in_valid & in_ready at posedge
//  in_regsel       in   REG_AW       destination register of the offered entry
//  in_data         in   DATA_W       data of the offered entry
//  wr_hold         in   1            RF write port busy: suppresses retire this cycle
//  rf_write        out  1            RF write enable (drives rf write)
//  rf_writeregsel  out  REG_AW       head entry register (drives rf writeregsel)
//  rf_writedata    out  DATA_W       head entry data (drives rf writedata)
//  rd1_sel         in   REG_AW       RF read port 1 select being issued this cycle
//  rd2_sel         in   REG_AW       RF read port 2 select being issued this cycle
//  byp1_hit        out  1            a queued entry targets rd1_sel
//  byp1_data       out  DATA_W       data of the youngest matching entry; 0 if no hit
//  byp2_hit        out  1            same as byp1_hit, for rd2_sel
//  byp2_data       out  DATA_W       same as byp1_data, for rd2_sel
//  count           out  $clog2(DEPTH)+1  number of occupied entries
//  err             out  1            sticky overflow flag
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-low.
//  - Reset (rst=0), applied at any time:
//    - head/tail pointers, count and err go to 0 immediately; queued entries are discarded.
//    - Entry storage need not be cleared.
//    - Outputs during and after reset: in_ready=1, rf_write=0, rf_writeregsel=0, rf_writedata=0, byp*_hit=0, byp*_data=0.
//  - Storage: circular buffer with head (oldest) and tail (next free) pointers.
//    - Pointers are REG index mod DEPTH and wrap from DEPTH-1 to 0.
//    - count is a separate register; no "full" inference from pointer equality.
//  - Occupancy states, derived from count:
//    - EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
//    - in_ready = (count != DEPTH), from registered state only; no combinational path from wr_hold or in_valid.
//  - Push: in_valid & in_ready at posedge writes {in_regsel,in_data} at tail; tail++.
//  - Pop/retire: rf_write = (count != 0) & ~wr_hold.
//    - rf_writeregsel/rf_writedata show the head entry whenever count != 0; 0 when EMPTY.
//    - When rf_write=1 the RF commits the entry at posedge and the same edge pops it (head++).
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//    - Push into EMPTY with no pop: entry appears on the rf_* outputs the cycle after the accepting edge.
//    - Minimum latency from handshake to RF commit is therefore 1 cycle.
//  - No pass-through: an entry offered while EMPTY is never written to the RF in the same cycle.
//  - Overflow: in_valid=1 while in_ready=0 sets err at that posedge.
//    - The offered entry is dropped; the producer is expected to hold it.
//    - err stays 1 until reset.
//  - Bypass (combinational): compare rdN_sel against every occupied entry, including the head being retired this cycle.
//    - Youngest match (closest to tail) wins.
//    - No match or EMPTY: byp_hit=0, data=0.
//    - Register 0 is an ordinary register: it is matched and written like any other.
//  - Ordering: entries retire strictly in push order; duplicate destinations are all written, oldest first.
// TESTING
//  1. Reset: rst=0 with 2 entries queued -> same cycle count=0, rf_write=0, in_ready=1, err=0; after release the queue stays EMPTY.
//  2. Single write: push r5=0xBEEF, wr_hold=0 -> next cycle rf_write=1, sel=5, data=0xBEEF; cycle after that rf_write=0, count=0.
//  3. Fill/overflow (DEPTH=2): wr_hold=1, push r1=0x0001, r2=0x0002, then offer r3.
//     - After the second push in_ready=0; offering r3 sets err=1 and count stays 2.
//     - Drop wr_hold -> r1 then r2 retire on consecutive cycles; r3 is never written.
//  4. Bypass: wr_hold=1, push r2=0x1111 then r2=0x2222; rd1_sel=2, rd2_sel=3.
//     - Expect byp1_hit=1, byp1_data=0x2222, byp2_hit=0, byp2_data=0.
//  5. Streaming/wrap: push one entry per cycle for 10 cycles (r0..r7,r0,r1; data=i), wr_hold=0.
//     - count holds 1, pointers wrap, RF receives all 10 writes in order, err=0.
//  6. Hold mid-stream: during test 5 pulse wr_hold for 2 cycles.
//     - rf_write=0 in those cycles, count rises to 2 and in_ready drops; no entry is lost or reordered.

Source files
------------

// File: rtl/rf_wb_queue.sv
// Register-file write-back FIFO with pending-write bypass; commit latency >= 1 cycle after accept.
// Backpressure: in_ready falls only when full (registered); an offer while not ready is dropped and sets sticky err.
module rf_wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_AW-1:0]        in_regsel,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wr_hold,
  output logic                     rf_write,
  output logic [REG_AW-1:0]        rf_writeregsel,
  output logic [DATA_W-1:0]        rf_writedata,
  input  logic [REG_AW-1:0]        rd1_sel,
  input  logic [REG_AW-1:0]        rd2_sel,
  output logic                     byp1_hit,
  output logic [DATA_W-1:0]        byp1_data,
  output logic                     byp2_hit,
  output logic [DATA_W-1:0]        byp2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] r_sel [DEPTH];
  logic [DATA_W-1:0] r_dat [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [PW-1:0]     w_idx;

  assign w_nonempty     = (r_count != '0);
  assign in_ready       = (r_count != CW'(DEPTH));
  assign rf_write       = w_nonempty & ~wr_hold;
  assign rf_writeregsel = w_nonempty ? r_sel[r_head] : '0;
  assign rf_writedata   = w_nonempty ? r_dat[r_head] : '0;
  assign count          = r_count;
  assign err            = r_err;

  assign w_push = in_valid & in_ready;
  assign w_pop  = rf_write;

  // Storage is never cleared: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sel[r_tail] <= in_regsel;
      r_dat[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && !in_ready) r_err <= 1'b1;
    end
  end

  // Walk oldest to youngest so a later match overrides: youngest pending write wins.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    w_idx     = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if (r_sel[w_idx] == rd1_sel) begin
          byp1_hit  = 1'b1;
          byp1_data = r_dat[w_idx];
        end
        if (r_sel[w_idx] == rd2_sel) begin
          byp2_hit  = 1'b1;
          byp2_data = r_dat[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_rf_wb_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_regsel;
  logic [15:0] in_data;
  logic        wr_hold;
  logic        rf_write;
  logic [2:0]  rf_writeregsel;
  logic [15:0] rf_writedata;
  logic [2:0]  rd1_sel;
  logic [2:0]  rd2_sel;
  logic        byp1_hit;
  logic [15:0] byp1_data;
  logic        byp2_hit;
  logic [15:0] byp2_data;
  logic [1:0]  count;
  logic        err;

  always #5 clk = ~clk;

  rf_wb_queue #(.DEPTH(DEPTH), .DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_regsel(in_regsel), .in_data(in_data),
    .wr_hold(wr_hold),
    .rf_write(rf_write), .rf_writeregsel(rf_writeregsel), .rf_writedata(rf_writedata),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data), .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .count(count), .err(err)
  );

  typedef struct {
    logic [2:0]  s;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  logic m_err;
  int   n_chk;
  int   n_err;
  int   n_commit;
  logic [15:0] commit_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        e_hit1, e_hit2;
    logic [15:0] e_d1, e_d2;
    int          n;
    n = q.size();
    e_hit1 = 0; e_hit2 = 0; e_d1 = 0; e_d2 = 0;
    foreach (q[k]) begin
      if (q[k].s == rd1_sel) begin e_hit1 = 1; e_d1 = q[k].d; end
      if (q[k].s == rd2_sel) begin e_hit2 = 1; e_d2 = q[k].d; end
    end
    chk("count",    32'(count),          32'(n));
    chk("in_ready", 32'(in_ready),       32'(n != DEPTH));
    chk("rf_write", 32'(rf_write),       32'(n != 0 && !wr_hold));
    chk("wr_sel",   32'(rf_writeregsel), (n != 0) ? 32'(q[0].s) : 32'd0);
    chk("wr_data",  32'(rf_writedata),   (n != 0) ? 32'(q[0].d) : 32'd0);
    chk("byp1_hit", 32'(byp1_hit),       32'(e_hit1));
    chk("byp1_dat", 32'(byp1_data),      32'(e_d1));
    chk("byp2_hit", 32'(byp2_hit),       32'(e_hit2));
    chk("byp2_dat", 32'(byp2_data),      32'(e_d2));
    chk("err",      32'(err),            32'(m_err));
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit full, pop;
    #1;
    if (!rst) begin
      q.delete();
      m_err = 0;
    end
    check_model();
    @(posedge clk);
    if (rst) begin
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && !wr_hold;
      if (pop) begin
        commit_log.push_back(q[0].d);
        void'(q.pop_front());
      end
      if (in_valid && !full) q.push_back('{s: in_regsel, d: in_data});
      if (in_valid && full) m_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [2:0] s, input logic [15:0] d);
    in_valid = 1; in_regsel = s; in_data = d;
  endtask

  initial begin
    int i, budget;
    n_chk = 0; n_err = 0; m_err = 0;
    rst = 0; in_valid = 0; in_regsel = 0; in_data = 0; wr_hold = 0; rd1_sel = 0; rd2_sel = 0;

    // Reset state
    @(negedge clk);
    cyc();
    rst = 1;
    cyc();

    // Single write
    offer(3'd5, 16'hBEEF);
    cyc();
    in_valid = 0;
    #1;
    chk("t2_wr",   32'(rf_write), 32'd1);
    chk("t2_sel",  32'(rf_writeregsel), 32'd5);
    chk("t2_data", 32'(rf_writedata), 32'hBEEF);
    cyc();
    cyc();

    // Fill and overflow
    wr_hold = 1;
    offer(3'd1, 16'h0001); cyc();
    offer(3'd2, 16'h0002); cyc();
    offer(3'd3, 16'h0003);
    #1 chk("t3_rdy", 32'(in_ready), 32'd0);
    cyc();
    in_valid = 0;
    #1 chk("t3_err", 32'(err), 32'd1);
    chk("t3_cnt", 32'(count), 32'd2);
    commit_log.delete();
    wr_hold = 0;
    repeat (3) cyc();
    chk("t3_ncommit", 32'(commit_log.size()), 32'd2);
    if (commit_log.size() == 2) begin
      chk("t3_c0", 32'(commit_log[0]), 32'h0001);
      chk("t3_c1", 32'(commit_log[1]), 32'h0002);
    end

    // Reset with two entries queued
    wr_hold = 1;
    offer(3'd4, 16'h0044); cyc();
    offer(3'd6, 16'h0066); cyc();
    in_valid = 0;
    rst = 0;
    #1;
    chk("t1_cnt", 32'(count), 32'd0);
    chk("t1_wr",  32'(rf_write), 32'd0);
    chk("t1_rdy", 32'(in_ready), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    cyc();
    rst = 1;
    wr_hold = 0;
    cyc(); cyc();

    // Bypass youngest match
    wr_hold = 1;
    offer(3'd2, 16'h1111); cyc();
    offer(3'd2, 16'h2222); cyc();
    in_valid = 0; rd1_sel = 3'd2; rd2_sel = 3'd3;
    #1;
    chk("t4_h1", 32'(byp1_hit), 32'd1);
    chk("t4_d1", 32'(byp1_data), 32'h2222);
    chk("t4_h2", 32'(byp2_hit), 32'd0);
    chk("t4_d2", 32'(byp2_data), 32'd0);
    cyc();
    wr_hold = 0;
    repeat (3) cyc();

    // Streaming with a two-cycle hold pulse; producer only offers when ready
    commit_log.delete();
    i = 0; budget = 0;
    while (i < 10 && budget < 40) begin
      wr_hold  = (budget == 4 || budget == 5);
      in_valid = in_ready;
      in_regsel = 3'(i % 8);
      in_data   = 16'(i);
      if (in_ready) i++;
      rd1_sel = 3'($urandom_range(0, 7));
      rd2_sel = 3'($urandom_range(0, 7));
      cyc();
      budget++;
    end
    chk("t5_timeout", 32'(i), 32'd10);
    in_valid = 0; wr_hold = 0;
    repeat (4) cyc();
    chk("t5_ncommit", 32'(commit_log.size()), 32'd10);
    foreach (commit_log[k]) chk("t5_order", 32'(commit_log[k]), 32'(k));
    chk("t5_err", 32'(err), 32'd0);

    // Random traffic with one mid-run reset
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_regsel = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      wr_hold   = ($urandom_range(0, 3) == 0);
      rd1_sel   = 3'($urandom_range(0, 7));
      rd2_sel   = 3'($urandom_range(0, 7));
      rst       = (c != 200);
      cyc();
    end
    rst = 1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
